// File: rtl/ex_result_buffer.sv
// ex_result_buffer: captures ALU Result/Zero plus EX side-band fields into a
// small circular FIFO and presents them to MEM over valid/ready. It resolves
// branch-taken at capture time and counts refused pushes for perf debug.
module ex_result_buffer #(
    parameter int DEPTH       = 2,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [63:0]            in_result,
    input  logic                   in_zero,
    input  logic [4:0]             in_rd,
    input  logic                   in_regwrite,
    input  logic                   in_branch,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [63:0]            out_result,
    output logic                   out_zero,
    output logic [4:0]             out_rd,
    output logic                   out_regwrite,
    output logic                   branch_taken,
    output logic [STALL_CNT_W-1:0] stall_count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;

    typedef struct packed {
        logic [63:0] result;
        logic        zero;
        logic [4:0]  rd;
        logic        regwrite;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           head;
    logic [PTR_W-1:0] rptr, wptr;
    logic [CNT_W-1:0] count;
    logic             push, pop;

    // Ready looks only at occupancy: a full buffer refuses even if MEM pops.
    assign in_ready  = (count != CNT_W'(DEPTH));
    assign out_valid = (count != '0);

    // Flush wins over both ends, so neither handshake fires in a flush cycle.
    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    assign head         = mem[rptr];
    assign out_result   = out_valid ? head.result   : 64'd0;
    assign out_zero     = out_valid ? head.zero     : 1'b0;
    assign out_rd       = out_valid ? head.rd       : 5'd0;
    assign out_regwrite = out_valid ? head.regwrite : 1'b0;

    // Entry storage; written only on an accepted push, never modified after.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= '{result: in_result, zero: in_zero,
                           rd: in_rd, regwrite: in_regwrite};
        end
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH (power of two).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else if (flush) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + PTR_W'(1);
            if (pop)  rptr <= rptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // One-cycle taken pulse for an accepted beq-type entry with Zero set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) branch_taken <= 1'b0;
        else       branch_taken <= push && in_branch && in_zero;
    end

    // Saturating count of refused pushes; flush does not clear it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
        end else if (in_valid && !in_ready && !flush && stall_count != STALL_MAX) begin
            stall_count <= stall_count + STALL_CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_ex_result_buffer.sv
// Directed bench for ex_result_buffer: a queue-based model checked every
// cycle, plus literal expectations at key points of each scenario.
module tb_ex_result_buffer;
    localparam int DEPTH = 2;
    localparam int SW    = 3;
    localparam int SMAX  = (1 << SW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid, in_ready;
    logic [63:0]   in_result;
    logic          in_zero, in_regwrite, in_branch, flush;
    logic [4:0]    in_rd;
    logic          out_valid, out_ready, out_zero, out_regwrite, branch_taken;
    logic [63:0]   out_result;
    logic [4:0]    out_rd;
    logic [SW-1:0] stall_count;

    int vectors = 0;
    int miscompares = 0;

    ex_result_buffer #(.DEPTH(DEPTH), .STALL_CNT_W(SW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
        .in_zero(in_zero), .in_rd(in_rd), .in_regwrite(in_regwrite),
        .in_branch(in_branch), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_zero(out_zero), .out_rd(out_rd), .out_regwrite(out_regwrite),
        .branch_taken(branch_taken), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] result;
        logic        zero;
        logic [4:0]  rd;
        logic        rw;
    } ent_t;

    ent_t m_q[$];
    int   m_stall;
    bit   m_bt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: FIFO as a queue, updated from the inputs seen at each edge.
    always @(posedge clk or posedge reset) begin
        bit acc, dp;
        if (reset) begin
            m_q.delete();
            m_stall = 0;
            m_bt = 0;
        end else if (flush) begin
            m_q.delete();
            m_bt = 0;
        end else begin
            acc = (in_valid === 1'b1) && (m_q.size() < DEPTH);
            if ((in_valid === 1'b1) && m_q.size() == DEPTH && m_stall < SMAX) m_stall++;
            dp = (m_q.size() > 0) && (out_ready === 1'b1);
            if (dp) void'(m_q.pop_front());
            if (acc) m_q.push_back('{in_result, in_zero, in_rd, in_regwrite});
            m_bt = acc && in_branch && in_zero;
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        if (!reset) begin
            check("out_valid", 64'(out_valid), 64'(m_q.size() != 0));
            check("in_ready", 64'(in_ready), 64'(m_q.size() != DEPTH));
            check("out_result", out_result, (m_q.size() != 0) ? m_q[0].result : 64'd0);
            check("out_zero", 64'(out_zero), (m_q.size() != 0) ? 64'(m_q[0].zero) : 64'd0);
            check("out_rd", 64'(out_rd), (m_q.size() != 0) ? 64'(m_q[0].rd) : 64'd0);
            check("out_regwrite", 64'(out_regwrite), (m_q.size() != 0) ? 64'(m_q[0].rw) : 64'd0);
            check("branch_taken", 64'(branch_taken), 64'(m_bt));
            check("stall_count", 64'(stall_count), 64'(m_stall));
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [63:0] r, input logic z,
                         input logic [4:0] d, input logic w, input logic b);
        in_valid = v; in_result = r; in_zero = z; in_rd = d; in_regwrite = w; in_branch = b;
    endtask

    task automatic idle();
        drive(1'b0, 'x, 'x, 'x, 'x, 'x);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 64'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        step(); step();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        reset = 1'b0;

        // 1: reset mid-operation, checked between edges
        drive(1, 64'h11, 0, 5'd1, 1, 0); step();
        drive(1, 64'h22, 0, 5'd2, 1, 0); step();
        step();                                   // held push refused: stall
        check("pre_rst_stall", 64'(stall_count), 64'd1);
        idle();
        #2 reset = 1'b1;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_stall", 64'(stall_count), 64'd0);
        check("midrst_out_result", out_result, 64'd0);
        #1 reset = 1'b0;
        step();

        // 2: single push held by MEM stall, then popped
        drive(1, 64'h5, 0, 5'd3, 1, 0); step();
        idle();
        for (int i = 0; i < 4; i++) begin
            check("held_result", out_result, 64'h5);
            check("held_rd", 64'(out_rd), 64'd3);
            check("held_valid", 64'(out_valid), 64'd1);
            step();
        end
        out_ready = 1'b1; step();
        check("after_pop_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b0;
        // X on data while in_valid=0 must be harmless
        drive(1'b0, 'x, 'x, 'x, 'x, 'x); step(); step();

        // 3: fill, back-pressure, pop, drain order A B C
        drive(1, 64'hA, 0, 5'd10, 1, 0); step();
        check("fill_head_A", out_result, 64'hA);
        drive(1, 64'hB, 1, 5'd11, 0, 0); step();
        drive(1, 64'hC, 0, 5'd12, 1, 0);
        step(); step(); step();
        check("full_in_ready", 64'(in_ready), 64'd0);
        check("full_stall3", 64'(stall_count), 64'd3);
        out_ready = 1'b1; step();                 // pops A, push still refused
        check("head_B", out_result, 64'hB);
        check("stall_pop_cycle", 64'(stall_count), 64'd4);
        out_ready = 1'b0; step();                 // C accepted
        idle();
        check("head_B_again", out_result, 64'hB);
        out_ready = 1'b1; step();
        check("head_C", out_result, 64'hC);
        step();
        check("drained", 64'(out_valid), 64'd0);
        out_ready = 1'b0;

        // 4: streaming after a fresh reset
        reset = 1'b1; step(); reset = 1'b0; step();
        out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            drive(1, 64'(i), 0, 5'(i), 1, 0); step();
            check("stream_result", out_result, 64'(i));
            check("stream_valid", 64'(out_valid), 64'd1);
        end
        idle(); step();
        check("stream_empty", 64'(out_valid), 64'd0);
        check("stream_stall", 64'(stall_count), 64'd0);

        // 5: branch-taken resolution
        drive(1, 64'h0, 1, 5'd0, 0, 1); step();
        check("bt_taken", 64'(branch_taken), 64'd1);
        check("bt_stored", 64'(out_valid), 64'd1);
        idle(); step();
        check("bt_one_cycle", 64'(branch_taken), 64'd0);
        drive(1, 64'h7, 0, 5'd0, 0, 1); step();
        check("bt_not_zero", 64'(branch_taken), 64'd0);
        drive(1, 64'h0, 1, 5'd4, 1, 0); step();
        check("bt_not_branch", 64'(branch_taken), 64'd0);
        idle(); step(); step();
        out_ready = 1'b0;

        // 6: flush with two stored and a simultaneous taken-branch push
        drive(1, 64'h1, 0, 5'd1, 1, 0); step();
        drive(1, 64'h2, 0, 5'd2, 1, 0); step();
        flush = 1'b1;
        drive(1, 64'hD, 1, 5'd13, 1, 1); step();
        flush = 1'b0; idle();
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_ready", 64'(in_ready), 64'd1);
        check("flush_bt", 64'(branch_taken), 64'd0);
        check("flush_stall", 64'(stall_count), 64'd0);
        step();
        check("flush_no_D", 64'(out_valid), 64'd0);

        // Saturation, then flush keeps the count
        drive(1, 64'h31, 0, 5'd1, 1, 0); step();
        drive(1, 64'h32, 0, 5'd2, 1, 0); step();
        drive(1, 64'h33, 0, 5'd3, 1, 0);
        for (int i = 0; i < 10; i++) step();
        check("stall_sat", 64'(stall_count), 64'(SMAX));
        flush = 1'b1; step();
        flush = 1'b0; idle();
        check("stall_kept_by_flush", 64'(stall_count), 64'(SMAX));
        check("post_flush_empty", 64'(out_valid), 64'd0);
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
